pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Multi-cycle instruction sequencer that owns the program counter's pc_control input. Each instruction runs through four phases: fetch handshake with instruction memory, opcode/funct decode, wait for datapath completion, then a single PC update.
- Sits between the instruction memory and the program_counter block; the PC is clock-enabled by pc_step.
- Also provides halt and retire accounting.

Parameters:
IMEM_TIMEOUT, 16, max cycles imem_req may stay high without imem_ack (used only with IMEM_TIMEOUT_EN); legal range 1..255

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction word from imem, valid when imem_ack=1
imem_ack  in  1  imem handshake acknowledge
exec_done  in  1  datapath finished current instruction
alu_zero  in  1  ALU zero flag, sampled with exec_done
halt_req  in  1  request to stop sequencing at the next instruction boundary
imem_req  out  1  instruction fetch request
instr_reg  out  32  latched current instruction
exec_start  out  1  one-cycle pulse: datapath may begin the instruction
pc_step  out  1  one-cycle PC clock-enable strobe
pc_control  out  4  PC update select, meaningful only when pc_step=1
halted  out  1  sequencer in HALT
fault  out  1  sticky fetch-timeout flag
instr_count  out  32  retired-instruction counter

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state=IDLE; internal branch-decision and timeout registers cleared. Applies mid-instruction; no pc_step is issued for an in-flight instruction.
- All outputs are registered.
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT, ERR.
- IDLE:
  - halt_req=1 -> HALT.
  - Otherwise -> FETCH next cycle, with imem_req=1.
- FETCH:
  - imem_req held 1 until the edge where imem_ack=1.
  - On that edge: instr_reg<=instr, imem_req<=0, -> DECODE.
  - imem_ack while imem_req=0 is ignored.
- DECODE (1 cycle): classify instr_reg[31:26] opcode and [5:0] funct:
  - opcode 2 (J) or 3 (JAL) -> class JUMP, code 4'b0001.
  - opcode 0 with funct 0x08 (JR) or 0x09 (JALR) -> class REG, code 4'b0010.
  - opcode 4 (BEQ), 5 (BNE) -> class BRANCH.
  - All else -> class SEQ, code 4'b0000.
  - Transition -> EXEC with exec_start=1 for exactly one cycle.
- EXEC:
  - Wait for exec_done=1. It is accepted in any EXEC cycle, including the cycle exec_start is high.
  - For BRANCH: taken = alu_zero for BEQ, ~alu_zero for BNE, sampled on the exec_done edge.
  - Code becomes 4'b0011 if taken, else 4'b0000.
  - -> UPDATE.
- UPDATE (1 cycle):
  - pc_step=1, pc_control=code, instr_count+=1 (wraps 0xFFFFFFFF->0).
  - Next: halt_req=1 -> HALT, else -> FETCH with imem_req=1.
- HALT:
  - halted=1; no requests issued.
  - halt_req=0 -> FETCH next cycle, with halted=0.
- halt_req is sampled only in IDLE, UPDATE and HALT; an in-flight instruction always completes.
- Outside UPDATE: pc_step=0, pc_control=4'b0000. Codes 4'b0100-4'b1111 are never generated.
- Minimum throughput is 4 cycles per instruction: FETCH with immediate ack, DECODE, EXEC with immediate done, UPDATE.
- ERR (reachable only with IMEM_TIMEOUT_EN):
  - fault=1, imem_req=0, terminal until reset.
  - Reset is the only exit; fault stays sticky until then.

Optional Feature:
IMEM_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to FETCH and increments each FETCH cycle without imem_ack.
  - When it reaches IMEM_TIMEOUT without ack: -> ERR, fault=1, imem_req<=0.
  - Ack on the same edge the count reaches IMEM_TIMEOUT wins: normal DECODE, no fault.
- Undefined:
  - FETCH waits indefinitely; fault is tied 0; ERR state is absent.

Test Plan:
- Reset release, ack and done returned the same cycle, 3 SEQ instrs (opcode 0x08) -> imem_req rises 1 cycle after reset; pc_step pulses every 4 cycles with pc_control=0000; instr_count=3.
- BEQ (0x10000004) with alu_zero=1 at exec_done -> pc_control=0011 on pc_step. Repeat with alu_zero=0 -> 0000. BNE inverted accordingly.
- J (0x08000010) -> 0001; JR (funct 0x08, opcode 0) -> 0010; exec_done delayed 5 cycles -> exactly one pc_step, 1 cycle after done.
- halt_req raised during EXEC -> instruction retires (pc_step=1), then halted=1 with no imem_req. Drop halt_req -> imem_req next cycle, halted=0.
- rst_n pulsed low in EXEC -> all outputs 0 immediately, no pc_step; instr_count=0; sequencing restarts via IDLE->FETCH.
- With IMEM_TIMEOUT_EN, IMEM_TIMEOUT=4, ack withheld -> fault=1 after 4 FETCH cycles, imem_req=0, stays until reset. Ack on the 4th cycle -> no fault.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer driving the program counter's pc_control/pc_step.
// Define IMEM_TIMEOUT_EN to add a fetch-timeout watchdog with a terminal ERR state.
module pc_sequencer #(
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        imem_ack_i,
  input  logic        exec_done_i,
  input  logic        alu_zero_i,
  input  logic        halt_req_i,
  output logic        imem_req_o,
  output logic [31:0] instr_reg_o,
  output logic        exec_start_o,
  output logic        pc_step_o,
  output logic [3:0]  pc_control_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] instr_count_o
);

  if (IMEM_TIMEOUT < 1 || IMEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("IMEM_TIMEOUT must be in 1..255");
  end

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StUpdate, StHalt
`ifdef IMEM_TIMEOUT_EN
    , StErr
`endif
  } state_e;

  state_e      state_q;
  logic        imem_req_q, exec_start_q, pc_step_q, halted_q;
  logic [31:0] instr_q, count_q;
  logic [3:0]  pc_ctrl_q, code_q;
  logic        br_q, bne_q;

  logic [5:0]  opcode, funct;
  logic [3:0]  dec_code;
  logic        dec_br;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];

  // Jump/register codes are fixed at decode; branches resolve only on exec_done.
  always_comb begin
    dec_code = 4'b0000;
    dec_br   = 1'b0;
    case (opcode)
      6'd2, 6'd3: dec_code = 4'b0001;
      6'd0:       if (funct == 6'h08 || funct == 6'h09) dec_code = 4'b0010;
      6'd4, 6'd5: dec_br = 1'b1;
      default:    ;
    endcase
  end

`ifdef IMEM_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(IMEM_TIMEOUT - 1);
  logic [7:0] tmo_q;
  logic       fault_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      imem_req_q   <= 1'b0;
      exec_start_q <= 1'b0;
      pc_step_q    <= 1'b0;
      halted_q     <= 1'b0;
      instr_q      <= '0;
      count_q      <= '0;
      pc_ctrl_q    <= 4'b0000;
      code_q       <= 4'b0000;
      br_q         <= 1'b0;
      bne_q        <= 1'b0;
`ifdef IMEM_TIMEOUT_EN
      tmo_q        <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      exec_start_q <= 1'b0;
      pc_step_q    <= 1'b0;
      pc_ctrl_q    <= 4'b0000;
`ifdef IMEM_TIMEOUT_EN
      if (state_q != StFetch) tmo_q <= '0;
`endif
      case (state_q)
        StIdle: begin
          if (halt_req_i) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
          end
        end
        StFetch: begin
          if (imem_ack_i) begin
            instr_q    <= instr_i;
            imem_req_q <= 1'b0;
            state_q    <= StDecode;
          end
`ifdef IMEM_TIMEOUT_EN
          else if (tmo_q == TmoLast) begin
            imem_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= StErr;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        StDecode: begin
          code_q       <= dec_code;
          br_q         <= dec_br;
          bne_q        <= (opcode == 6'd5);
          exec_start_q <= 1'b1;
          state_q      <= StExec;
        end
        StExec: begin
          if (exec_done_i) begin
            pc_step_q <= 1'b1;
            if (br_q) pc_ctrl_q <= (alu_zero_i ^ bne_q) ? 4'b0011 : 4'b0000;
            else      pc_ctrl_q <= code_q;
            count_q   <= count_q + 32'd1;
            state_q   <= StUpdate;
          end
        end
        StUpdate: begin
          if (halt_req_i) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
          end
        end
        StHalt: begin
          if (!halt_req_i) begin
            state_q    <= StFetch;
            halted_q   <= 1'b0;
            imem_req_q <= 1'b1;
          end
        end
`ifdef IMEM_TIMEOUT_EN
        StErr: state_q <= StErr;
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req_o    = imem_req_q;
  assign instr_reg_o   = instr_q;
  assign exec_start_o  = exec_start_q;
  assign pc_step_o     = pc_step_q;
  assign pc_control_o  = pc_ctrl_q;
  assign halted_o      = halted_q;
  assign instr_count_o = count_q;
`ifdef IMEM_TIMEOUT_EN
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected PC updates, a monitor
// pops them on every pc_step. Timeout cases run when IMEM_TIMEOUT_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_ack = 1'b0, exec_done = 1'b0, alu_zero = 1'b0, halt_req = 1'b0;
  logic        imem_req, exec_start, pc_step, halted, fault;
  logic [31:0] instr_reg, instr_count;
  logic [3:0]  pc_control;

  pc_sequencer #(.IMEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .imem_ack_i(imem_ack),
    .exec_done_i(exec_done), .alu_zero_i(alu_zero), .halt_req_i(halt_req),
    .imem_req_o(imem_req), .instr_reg_o(instr_reg), .exec_start_o(exec_start),
    .pc_step_o(pc_step), .pc_control_o(pc_control), .halted_o(halted),
    .fault_o(fault), .instr_count_o(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] count;
  } exp_t;

  exp_t        exp_q[$];
  int          step_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  logic [31:0] exp_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pc_step must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pc_step) begin
        step_q.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_pc_step", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pc_control", pc_control, e.code);
          chk("instr_count", instr_count, e.count);
        end
      end
    end
  end

  task automatic run_instr(input logic [31:0] w, input int ack_dly, input int dly,
                           input logic z, input logic hreq, input logic [3:0] code);
    int n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    if (!imem_req) begin chk("fetch_req_wait", 0, 1); return; end
    repeat (ack_dly) @(negedge clk);
    instr = w;
    imem_ack = 1'b1;
    exp_count++;
    exp_q.push_back('{code: code, count: exp_count});
    @(negedge clk);
    imem_ack = 1'b0;
    instr = ~w;
    chk("instr_reg_latch", instr_reg, w);
    n = 0;
    while (!exec_start && n < 50) begin @(negedge clk); n++; end
    if (!exec_start) begin chk("exec_start_wait", 0, 1); return; end
    alu_zero = ~z;
    repeat (dly) @(negedge clk);
    exec_done = 1'b1;
    alu_zero = z;
    halt_req = hreq;
    done_cyc = cyc;
    @(negedge clk);
    exec_done = 1'b0;
    alu_zero = ~z;
    chk("exec_start_pulse", exec_start, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {imem_req, instr_reg, exec_start, pc_step, pc_control, halted, fault,
                          instr_count}, 0);
    rst_n = 1'b1;
    chk("req_low_at_release", imem_req, 0);
    @(negedge clk);
    chk("req_after_reset", imem_req, 1);

    // Back-to-back SEQ instructions: 4 cycles per retirement
    n = step_q.size();
    run_instr(32'h2000_0001, 0, 0, 1'b0, 1'b0, 4'b0000);
    run_instr(32'h2000_0002, 0, 0, 1'b1, 1'b0, 4'b0000);
    run_instr(32'h2000_0003, 0, 0, 1'b0, 1'b0, 4'b0000);
    settle();
    chk("seq_count", instr_count, 3);
    if (step_q.size() == n + 3) begin
      chk("seq_spacing_1", step_q[n+1] - step_q[n], 4);
      chk("seq_spacing_2", step_q[n+2] - step_q[n+1], 4);
    end else chk("seq_step_count", step_q.size(), n + 3);

    // Branches, jumps and register jumps
    run_instr(32'h1000_0004, 0, 0, 1'b1, 1'b0, 4'b0011);  // BEQ taken
    run_instr(32'h1000_0004, 0, 0, 1'b0, 1'b0, 4'b0000);  // BEQ not taken
    run_instr(32'h1400_0004, 0, 0, 1'b0, 1'b0, 4'b0011);  // BNE taken
    run_instr(32'h1400_0004, 0, 1, 1'b1, 1'b0, 4'b0000);  // BNE not taken
    run_instr(32'h0800_0010, 0, 0, 1'b0, 1'b0, 4'b0001);  // J
    run_instr(32'h0C00_0000, 2, 0, 1'b1, 1'b0, 4'b0001);  // JAL
    run_instr(32'h03E0_0008, 0, 0, 1'b1, 1'b0, 4'b0010);  // JR
    run_instr(32'h0000_0009, 0, 0, 1'b0, 1'b0, 4'b0010);  // JALR
    run_instr(32'h0000_0020, 0, 0, 1'b1, 1'b0, 4'b0000);  // ADD (opcode 0, other funct)
    settle();

    // Delayed exec_done: single pc_step one cycle after done
    n = step_q.size();
    run_instr(32'h0800_0020, 0, 5, 1'b0, 1'b0, 4'b0001);
    settle();
    chk("delayed_step_count", step_q.size(), n + 1);
    chk("delayed_step_timing", step_q[$], done_cyc + 1);

    // Halt raised during EXEC: instruction retires, then HALT
    run_instr(32'h2000_0004, 0, 1, 1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    chk("halt_entered", {halted, imem_req}, 2'b10);
    repeat (3) @(negedge clk);
    chk("halt_holds", {halted, imem_req, pc_step}, 3'b100);
    halt_req = 1'b0;
    @(negedge clk);
    chk("halt_release", {halted, imem_req}, 2'b01);
    chk("halt_no_stray_step", exp_q.size(), 0);

    // Reset in EXEC: aborted instruction never steps the PC
    instr = 32'h1000_0004;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    n = 0;
    while (!exec_start && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {imem_req, instr_reg, exec_start, pc_step, pc_control, halted,
                                   fault, instr_count}, 0);
    exp_count = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", imem_req, 1);
    run_instr(32'h2000_0005, 0, 0, 1'b0, 1'b0, 4'b0000);
    settle();
    chk("restart_count", instr_count, 1);

`ifdef IMEM_TIMEOUT_EN
    // Ack on the last allowed fetch cycle wins over the timeout
    run_instr(32'h2000_0006, 3, 0, 1'b0, 1'b0, 4'b0000);
    settle();
    chk("late_ack_no_fault", fault, 0);
    repeat (3) @(negedge clk);
    chk("fetch_before_timeout", {fault, imem_req}, 2'b01);
    @(negedge clk);
    chk("timeout_fault", {fault, imem_req}, 2'b10);
    imem_ack = 1'b1;
    repeat (4) @(negedge clk);
    imem_ack = 1'b0;
    chk("fault_sticky", {fault, imem_req, pc_step}, 3'b100);
    rst_n = 1'b0;
    #1 chk("fault_cleared_by_reset", fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    repeat (20) @(negedge clk);
    chk("fetch_waits_forever", {fault, imem_req, pc_step}, 3'b010);
    run_instr(32'h2000_0007, 0, 0, 1'b0, 1'b0, 4'b0000);
    settle();
`endif
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
